main_ctrl_fsm: RTL
==================

// Module: main_ctrl_fsm
// PURPOSE
//  Multi-cycle main control unit. Decodes the 6-bit instruction opcode and sequences
//  FETCH/DECODE/EXEC/MEM/WB, driving datapath enables, memory strobes and the 2-bit
//  alu_op consumed by the ALU function controller (10=R-type, 00=add, 01=sub).
//  Sits between the instruction register and the datapath; memory accesses stall on mem_ready.
// PARAMETERS
//  WAIT_W    4   width of the memory wait-state counter
//  MAX_WAIT  15  mem_ready-low cycles tolerated in FETCH/MEM before bus_err (<= 2**WAIT_W-1)
// PORTS
//  clk          in   1  single clock, all state on rising edge
//  rst_n        in   1  asynchronous, active-low reset
//  opcode       in   6  IR[31:26]; sampled in DECODE only
//  mem_ready    in   1  memory access complete this cycle
//  alu_op       out  2  10 R-type, 00 add (addi/lw/sw/PC+4), 01 sub (subi)
//  alu_src_a    out  1  0 PC, 1 register A
//  alu_src_b    out  2  00 reg B, 01 const 4, 10 sign-extended immediate
//  iord         out  1  0 instruction address (PC), 1 data address (ALUOut)
//  mem_read     out  1  memory read strobe
//  mem_write    out  1  memory write strobe
//  ir_write     out  1  load IR
//  pc_write     out  1  load PC with ALU result
//  reg_write    out  1  register file write enable
//  reg_dst      out  1  1 rd (R-type), 0 rt
//  mem_to_reg   out  1  1 write-back from MDR, 0 from ALUOut
//  instr_done   out  1  1-cycle pulse when an instruction retires
//  illegal_op   out  1  1-cycle pulse, unknown opcode in DECODE
//  bus_err      out  1  1-cycle pulse, wait-state timeout
// BEHAVIOUR
//  Opcodes: R 000000, addi 001100, subi 001101, sw 010000, lw 010001; all others illegal.
//  Reset: state=FETCH, op_q=0, wait_cnt=0; while rst_n=0 every output is 0.
//  Outputs are decoded from state and op_q; ir_write/pc_write also need mem_ready.
//  Unlisted outputs are 0 in every state.
//  FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00.
//   mem_ready=1: ir_write=pc_write=1, go DECODE; else stay and increment wait_cnt.
//  DECODE: op_q<=opcode. Legal: go EXEC. Illegal: illegal_op=1, go FETCH, no writes.
//  EXEC: alu_src_a=1. R: alu_op=10, src_b=00. addi: 00/10. subi: 01/10. lw,sw: 00/10.
//   lw/sw go MEM; others go WB.
//  MEM: iord=1. lw: mem_read=1. sw: mem_write=1. Strobes held until mem_ready.
//   On mem_ready: lw goes WB; sw pulses instr_done and goes FETCH.
//  WB: reg_write=1, reg_dst=(op_q==R), mem_to_reg=(op_q==lw), instr_done=1, go FETCH.
//  Zero-wait latency, FETCH entry to next FETCH: R/addi/subi 4, sw 4, lw 5, illegal 2.
//  wait_cnt clears on every state change.
//  wait_cnt==MAX_WAIT with mem_ready=0: bus_err=1, wait_cnt<=0, go FETCH.
//   PC/IR/register file untouched, no instr_done.
//  mem_ready in the same cycle as the timeout: the completion wins and bus_err is not raised.
//  mem_ready is ignored outside FETCH/MEM; opcode changes after DECODE have no effect.
//  Reset asserted mid-instruction: outputs go 0 immediately, no partial write-back.
//   Restart from FETCH after release.
//  Encoding of unreachable states: recover to FETCH.
// STRUCTURE
//  ctrl_pkg: opcode constants, ALUop codes (ALU_R/ALU_ADD/ALU_SUB), alu_src_b codes,
//   state encoding. The package is shared with the ALU function controller.
//  Sub-module mem_wait_timer: clear, count-enable, MAX_WAIT compare, timeout output.
//  FSM and output decode stay in this module.
// TESTING
//  1. R-type, mem_ready always 1: FETCH,DECODE,EXEC,WB. EXEC shows alu_op=10, src_b=00.
//     WB shows reg_write=1, reg_dst=1 and instr_done once; 4 cycles total.
//  2. lw with 2 wait cycles in MEM: mem_read and iord held 3 cycles.
//     WB then shows mem_to_reg=1, reg_dst=0; 7 cycles total.
//  3. sw, then subi: sw pulses mem_write for 1 cycle and retires from MEM, no reg_write.
//     subi EXEC shows alu_op=01, alu_src_b=10.
//  4. Opcode 111111: illegal_op pulses in DECODE; no reg_write or mem_write.
//     FETCH again at cycle 3.
//  5. mem_ready held 0 in FETCH: bus_err on the 16th cycle (MAX_WAIT=15), return to FETCH.
//     Repeat with mem_ready=1 on that cycle: no bus_err.
//  6. Drop rst_n during lw MEM: all outputs 0 asynchronously.
//     After release, FETCH with mem_read=1 on the first clock.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control definitions: opcodes, ALU operation codes, operand-B select codes and the
// main controller state encoding. Also used by the ALU function controller.
package ctrl_pkg;

  // Instruction opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001100;
  localparam logic [5:0] OP_SUBI  = 6'b001101;
  localparam logic [5:0] OP_SW    = 6'b010000;
  localparam logic [5:0] OP_LW    = 6'b010001;

  // alu_op codes handed to the ALU function controller
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;

  // alu_src_b select codes
  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } ctrl_state_e;

  function automatic logic is_legal_op(input logic [5:0] op);
    logic legal;
    case (op)
      OP_RTYPE, OP_ADDI, OP_SUBI, OP_SW, OP_LW: legal = 1'b1;
      default:                                  legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles and flags when the count has reached MAX_WAIT.
module mem_wait_timer #(
  parameter int unsigned WAIT_W   = 4,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic timeout
);

  logic [WAIT_W-1:0] wait_cnt_q;

  // Clear has priority over counting; the owner stops counting once timeout is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else if (clear) begin
      wait_cnt_q <= '0;
    end else if (count_en) begin
      wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
    end
  end

  // Counter has tolerated MAX_WAIT stalled cycles already
  always_comb begin
    timeout = (wait_cnt_q == WAIT_W'(MAX_WAIT));
  end

endmodule

// File: rtl/main_ctrl_fsm.sv
// Multi-cycle main control unit: sequences FETCH/DECODE/EXEC/MEM/WB and decodes datapath
// enables, memory strobes and alu_op from the current state and the latched opcode.
module main_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned WAIT_W   = 4,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       bus_err
);

  ctrl_state_e state_q, state_d;
  logic [5:0]  op_q;
  logic        mem_phase;
  logic        stall;
  logic        timeout;
  logic        timeout_hit;
  logic        timer_clear;
  logic        timer_count;

  // A timeout only counts when the access is still stalled; a late mem_ready wins.
  always_comb begin
    mem_phase   = (state_q == StFetch) || (state_q == StMem);
    stall       = mem_phase && !mem_ready;
    timeout_hit = stall && timeout;
    timer_count = stall && !timeout;
    timer_clear = (state_d != state_q) || timeout_hit;
  end

  mem_wait_timer #(
    .WAIT_W  (WAIT_W),
    .MAX_WAIT(MAX_WAIT)
  ) u_mem_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .count_en(timer_count),
    .timeout (timeout)
  );

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: begin
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        state_d = is_legal_op(opcode) ? StExec : StFetch;
      end
      StExec: begin
        state_d = ((op_q == OP_LW) || (op_q == OP_SW)) ? StMem : StWb;
      end
      StMem: begin
        if (mem_ready) begin
          state_d = (op_q == OP_LW) ? StWb : StFetch;
        end else if (timeout_hit) begin
          state_d = StFetch;
        end
      end
      StWb:    state_d = StFetch;
      default: state_d = StFetch;
    endcase
  end

  // State register and opcode latch; opcode is captured only in DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) op_q <= opcode;
    end
  end

  // Output decode; everything is forced low while reset is asserted
  always_comb begin
    alu_op     = ALU_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_REG;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    bus_err    = 1'b0;
    if (rst_n) begin
      case (state_q)
        StFetch: begin
          mem_read  = 1'b1;
          alu_src_b = SRC_B_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          bus_err   = timeout_hit;
        end
        StDecode: begin
          illegal_op = !is_legal_op(opcode);
        end
        StExec: begin
          alu_src_a = 1'b1;
          alu_src_b = SRC_B_IMM;
          case (op_q)
            OP_RTYPE: begin
              alu_op    = ALU_R;
              alu_src_b = SRC_B_REG;
            end
            OP_SUBI: alu_op = ALU_SUB;
            default: alu_op = ALU_ADD;
          endcase
        end
        StMem: begin
          iord       = 1'b1;
          mem_read   = (op_q == OP_LW);
          mem_write  = (op_q == OP_SW);
          instr_done = (op_q == OP_SW) && mem_ready;
          bus_err    = timeout_hit;
        end
        StWb: begin
          reg_write  = 1'b1;
          reg_dst    = (op_q == OP_RTYPE);
          mem_to_reg = (op_q == OP_LW);
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
